// File: rtl/fht_pkg.sv
// Shared types and constants for the FHT working-memory front/back ends.
package fht_pkg;

  localparam int DEF_A_BIT = 8;
  localparam int DEF_D_BIT = 16;
  localparam int N_BANK    = 4;
  localparam int N_POINT   = N_BANK << DEF_A_BIT;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    KICK,
    WAIT_LO,
    WAIT_HI
  } state_t;

  // Reverses the low w bits of v; bits at and above w come back zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    logic [4:0]  j;
    r = '0;
    j = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        j    = 5'(w - 1 - i);
        r[i] = v[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_bitrev_map.sv
// Sample index -> (bank, address) mapping for the 4-bank FHT memory.
// FHT_LOAD_BITREV_EN defined: bit-reversed order; undefined: natural order.
module fht_bitrev_map
  import fht_pkg::*;
#(
  parameter int A_BIT = DEF_A_BIT
) (
  input  logic [A_BIT+1:0] k_idx,
  output logic [1:0]       bank,
  output logic [A_BIT-1:0] addr
);

  localparam int KW = A_BIT + 2;

  logic [KW-1:0] r;

`ifdef FHT_LOAD_BITREV_EN
  assign r = KW'(bit_rev(32'(k_idx), KW));
`else
  assign r = k_idx;
`endif

  assign bank = r[1:0];
  assign addr = r[KW-1:2];

endmodule

// File: rtl/fht_input_loader.sv
// Serial sample loader for the 4-bank FHT memory; kicks the FHT control per frame.
// Index order selected by FHT_LOAD_BITREV_EN (see fht_bitrev_map).
module fht_input_loader
  import fht_pkg::*;
#(
  parameter int A_BIT = DEF_A_BIT,
  parameter int D_BIT = DEF_D_BIT
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iCLEAR,
  input  logic [D_BIT-1:0]  iDATA,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic              iFHT_RDY,
  output logic              oSTART,
  output logic [A_BIT-1:0]  oADDR_WR,
  output logic [D_BIT-1:0]  oDATA_WR,
  output logic [N_BANK-1:0] oWE,
  output logic              oBUSY,
  output state_t            dbg_state,
  output logic [A_BIT+1:0]  dbg_k
);

  // Handshake: a sample transfers on a cycle where iVALID and oREADY are both
  // high; iDATA must be stable while iVALID is high, oREADY never depends on iVALID.

  state_t             state;
  state_t             state_nxt;
  logic [A_BIT+1:0]   k;
  logic [1:0]         map_bank;
  logic [A_BIT-1:0]   map_addr;
  logic               accept;
  logic               wr_en;
  logic               last;

  fht_bitrev_map #(
    .A_BIT (A_BIT)
  ) u_map (
    .k_idx (k),
    .bank  (map_bank),
    .addr  (map_addr)
  );

  assign accept = iVALID & (state == LOAD);
  assign wr_en  = accept & ~iCLEAR;
  assign last   = accept & (&k);

  always_comb begin
    state_nxt = state;
    oREADY    = 1'b0;
    oSTART    = 1'b0;
    oBUSY     = 1'b1;
    case (state)
      IDLE: begin
        oBUSY = 1'b0;
        if (iFHT_RDY) state_nxt = LOAD;
      end
      LOAD: begin
        oREADY = 1'b1;
        if (last) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = KICK;
      KICK: begin
        oSTART    = 1'b1;
        state_nxt = WAIT_LO;
      end
      WAIT_LO: if (!iFHT_RDY) state_nxt = WAIT_HI;
      WAIT_HI: if (iFHT_RDY) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything, including the final accept of a frame.
    if (iCLEAR) state_nxt = IDLE;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state    <= IDLE;
      k        <= '0;
      oWE      <= '0;
      oADDR_WR <= '0;
      oDATA_WR <= '0;
    end else begin
      state <= state_nxt;
      oWE   <= '0;
      if (iCLEAR) begin
        k <= '0;
      end else if (accept) begin
        k <= k + 1'b1;
      end
      if (wr_en) begin
        oWE      <= N_BANK'(1) << map_bank;
        oADDR_WR <= map_addr;
        oDATA_WR <= iDATA;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_k     = k;

endmodule

// File: tb/tb_fht_input_loader.sv
// Self-checking bench for fht_input_loader: mapping table, frame scoreboard, corner sequences.
module tb_fht_input_loader;
  import fht_pkg::*;

  localparam int A_BIT = 8;
  localparam int D_BIT = 16;
  localparam int N     = N_POINT;

  logic              iCLK;
  logic              iRESET;
  logic              iCLEAR;
  logic [D_BIT-1:0]  iDATA;
  logic              iVALID;
  logic              oREADY;
  logic              iFHT_RDY;
  logic              oSTART;
  logic [A_BIT-1:0]  oADDR_WR;
  logic [D_BIT-1:0]  oDATA_WR;
  logic [3:0]        oWE;
  logic              oBUSY;
  state_t            dbg_state;
  logic [A_BIT+1:0]  dbg_k;

  fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .iCLEAR    (iCLEAR),
    .iDATA     (iDATA),
    .iVALID    (iVALID),
    .oREADY    (oREADY),
    .iFHT_RDY  (iFHT_RDY),
    .oSTART    (oSTART),
    .oADDR_WR  (oADDR_WR),
    .oDATA_WR  (oDATA_WR),
    .oWE       (oWE),
    .oBUSY     (oBUSY),
    .dbg_state (dbg_state),
    .dbg_k     (dbg_k)
  );

  // ---------------- clock / reset ----------------
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int cyc = 0;
  always @(posedge iCLK) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int last_acc_cyc = 0;
  int dup_cnt   = 0;
  int wcount [4];
  logic [15:0] mem [4][256];
  logic        written [4][256];
  logic [27:0] exp_q [$];
  int          exp_cyc_q [$];
  logic [27:0] mon_act;
  logic [27:0] mon_exp;
  int          mon_cyc;

  typedef struct {
    int         k;
    logic [1:0] bank;
    logic [7:0] addr;
  } map_vec_t;
  map_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask

  function automatic logic [9:0] model_r(input logic [9:0] kk);
    logic [9:0] r;
`ifdef FHT_LOAD_BITREV_EN
    for (int i = 0; i < 10; i++) r[i] = kk[9-i];
`else
    r = kk;
`endif
    return r;
  endfunction

  // Write monitor: checks every bank write against the expected queue and its due cycle.
  always @(negedge iCLK) begin
    if (oSTART) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (oWE != 4'd0 || (exp_q.size() != 0 && exp_cyc_q[0] <= cyc)) begin
      mon_act = {oWE, oADDR_WR, oDATA_WR};
      if (oWE != 4'd0) chk("we_onehot", 32'($onehot(oWE)), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(oWE), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        chk("write_record", 32'(mon_act), 32'(mon_exp));
        chk("write_latency", 32'(cyc), 32'(mon_cyc));
      end
      for (int b = 0; b < 4; b++) begin
        if (oWE[b]) begin
          if (written[b][oADDR_WR]) dup_cnt++;
          written[b][oADDR_WR] = 1'b1;
          mem[b][oADDR_WR]     = oDATA_WR;
          wcount[b]++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_mem;
    for (int b = 0; b < 4; b++) begin
      wcount[b] = 0;
      for (int a = 0; a < 256; a++) begin
        written[b][a] = 1'b0;
        mem[b][a]     = 16'd0;
      end
    end
    dup_cnt = 0;
  endtask

  task automatic send(input int n, input int duty, input logic [15:0] key);
    int acc = 0;
    int guard = 0;
    logic [9:0] kk;
    logic [9:0] r;
    while (acc < n && guard < 20000) begin
      iVALID = (int'($urandom_range(0, 99)) < duty);
      kk     = 10'(acc);
      iDATA  = {6'd0, kk} ^ key;
      if (iVALID && oREADY) begin
        r = model_r(kk);
        exp_q.push_back({4'b0001 << r[1:0], r[9:2], iDATA});
        exp_cyc_q.push_back(cyc + 1);
        last_acc_cyc = cyc;
        acc++;
      end
      tick;
      guard++;
    end
    iVALID = 1'b0;
    chk("send_accepts", 32'(acc), 32'(n));
  endtask

  task automatic check_start(input int base);
    int g = 0;
    while (start_cnt == base && g < 20) begin
      tick;
      g++;
    end
    tick;
    tick;
    chk("start_count", 32'(start_cnt - base), 32'd1);
    chk("start_latency", 32'(start_cyc - last_acc_cyc), 32'd2);
  endtask

  task automatic frame_check(input logic [15:0] key);
    int mism = 0;
    logic [9:0] r;
    for (int b = 0; b < 4; b++) chk($sformatf("bank%0d_writes", b), 32'(wcount[b]), 32'd256);
    chk("dup_addr", 32'(dup_cnt), 32'd0);
    for (int kk = 0; kk < N; kk++) begin
      r = model_r(10'(kk));
      if (mem[r[1:0]][r[9:2]] !== (16'(kk) ^ key)) mism++;
    end
    chk("mem_model", 32'(mism), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic finish_transform(input int hold_lo);
    int leak = 0;
    repeat (5) begin
      if (oREADY) leak++;
      tick;
    end
    iFHT_RDY = 1'b0;
    repeat (hold_lo) begin
      if (oREADY) leak++;
      tick;
    end
    chk("busy_during_xform", 32'(oBUSY), 32'd1);
    chk("ready_held_low", 32'(leak), 32'd0);
    iFHT_RDY = 1'b1;
    chk("ready_before_rise", 32'(oREADY), 32'd0);
    tick;
    chk("ready_after_rise", 32'(oREADY), 32'd1);
    chk("state_load_again", 32'(dbg_state), 32'(LOAD));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(oREADY), 32'd0);
    chk({tag, "_start"}, 32'(oSTART), 32'd0);
    chk({tag, "_we"},    32'(oWE), 32'd0);
    chk({tag, "_addr"},  32'(oADDR_WR), 32'd0);
    chk({tag, "_data"},  32'(oDATA_WR), 32'd0);
    chk({tag, "_busy"},  32'(oBUSY), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_k"},     32'(dbg_k), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  int base;
  int sum;

  initial begin
`ifdef FHT_LOAD_BITREV_EN
    vecs[0] = '{1,    2'd0, 8'd128};
    vecs[1] = '{2,    2'd0, 8'd64};
    vecs[2] = '{4,    2'd0, 8'd32};
    vecs[3] = '{256,  2'd2, 8'd0};
    vecs[4] = '{512,  2'd1, 8'd0};
    vecs[5] = '{1023, 2'd3, 8'd255};
`else
    vecs[0] = '{5,    2'd1, 8'd1};
    vecs[1] = '{1,    2'd1, 8'd0};
    vecs[2] = '{4,    2'd0, 8'd1};
    vecs[3] = '{256,  2'd0, 8'd64};
    vecs[4] = '{512,  2'd0, 8'd128};
    vecs[5] = '{1023, 2'd3, 8'd255};
`endif
    iRESET   = 1'b1;
    iCLEAR   = 1'b0;
    iDATA    = '0;
    iVALID   = 1'b0;
    iFHT_RDY = 1'b0;
    clear_mem();
    repeat (3) @(posedge iCLK);
    #1;
    check_zero_outputs("reset");
    @(negedge iCLK);
    iRESET = 1'b0;

    // Control not idle: must stay in IDLE.
    repeat (3) tick;
    chk("idle_hold_state", 32'(dbg_state), 32'(IDLE));
    chk("idle_hold_ready", 32'(oREADY), 32'd0);
    chk("idle_hold_busy", 32'(oBUSY), 32'd0);
    iFHT_RDY = 1'b1;
    tick;
    chk("enter_load_state", 32'(dbg_state), 32'(LOAD));
    chk("enter_load_ready", 32'(oREADY), 32'd1);
    chk("enter_load_busy", 32'(oBUSY), 32'd1);

    // Frame 1: continuous stream, then mapping table.
    clear_mem();
    base = start_cnt;
    send(N, 100, 16'h0000);
    check_start(base);
    frame_check(16'h0000);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("map_k%0d_written", vecs[i].k), 32'(written[vecs[i].bank][vecs[i].addr]), 32'd1);
      chk($sformatf("map_k%0d", vecs[i].k), 32'(mem[vecs[i].bank][vecs[i].addr]), 32'(vecs[i].k));
    end
    finish_transform(3000);

    // Frame 2: ~30% valid duty.
    clear_mem();
    base = start_cnt;
    send(N, 30, 16'hA5A5);
    check_start(base);
    frame_check(16'hA5A5);
    finish_transform(4);

    // Frame 3: abort coinciding with the final accept.
    clear_mem();
    base = start_cnt;
    send(N - 1, 100, 16'h0F0F);
    chk("pre_clear_ready", 32'(oREADY), 32'd1);
    chk("pre_clear_k", 32'(dbg_k), 32'd1023);
    iVALID = 1'b1;
    iCLEAR = 1'b1;
    iDATA  = 16'hDEAD;
    tick;
    iCLEAR = 1'b0;
    iVALID = 1'b0;
    chk("clear_state", 32'(dbg_state), 32'(IDLE));
    chk("clear_k", 32'(dbg_k), 32'd0);
    chk("clear_we", 32'(oWE), 32'd0);
    repeat (6) tick;
    chk("clear_no_start", 32'(start_cnt - base), 32'd0);
    sum = wcount[0] + wcount[1] + wcount[2] + wcount[3];
    chk("clear_write_total", 32'(sum), 32'(N - 1));

    // Frame 4: full frame after the abort.
    clear_mem();
    base = start_cnt;
    send(N, 100, 16'h1234);
    check_start(base);
    frame_check(16'h1234);
    finish_transform(4);

    // Frame 5: asynchronous reset mid-frame, then a clean reload.
    clear_mem();
    send(500, 100, 16'h5555);
    @(negedge iCLK);
    #1;
    iRESET = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    @(posedge iCLK);
    #1;
    iRESET = 1'b0;
    tick;
    chk("post_reset_load", 32'(dbg_state), 32'(LOAD));
    clear_mem();
    base = start_cnt;
    send(N, 100, 16'h7777);
    check_start(base);
    frame_check(16'h7777);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
